// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage behind the ALU.
// One outstanding word-bus op, lane steering, load extension, fault flags.
module load_store_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data,
  output logic            done,
  output logic            misalign,
  output logic            illegal,
  output logic            busy,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state;
  state_t state_nx;

  logic            accept;
  logic            bus_done;
  logic            f3_legal;
  logic            need_half;
  logic            need_word;
  logic            addr_misal;
  logic            issue;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mis_q;
  logic            ill_q;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign bus_done  = (state == BUS) && mem_ready;
  assign issue     = accept && f3_legal && !addr_misal;

  // Classify funct3 against direction and derive alignment needs.
  always_comb begin
    f3_legal  = 1'b0;
    need_half = 1'b0;
    need_word = 1'b0;
    case (req_funct3)
      F3_B: f3_legal = 1'b1;
      F3_H: begin
        f3_legal  = 1'b1;
        need_half = 1'b1;
      end
      F3_W: begin
        f3_legal  = 1'b1;
        need_word = 1'b1;
      end
      F3_BU: f3_legal = !req_we;
      F3_HU: begin
        f3_legal  = !req_we;
        need_half = 1'b1;
      end
      default: f3_legal = 1'b0;
    endcase
    addr_misal = (need_half && req_addr[0])
              || (need_word && (req_addr[1:0] != 2'b00));
  end

  // Replicate store data across lanes and build byte enables.
  always_comb begin
    st_strb = 4'b0000;
    st_data = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_strb = 4'b0001 << req_addr[1:0];
          st_data = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
          st_data = {2{req_wdata[15:0]}};
        end
        2'b10: begin
          st_strb = 4'b1111;
          st_data = req_wdata;
        end
        default: begin
          st_strb = 4'b0000;
          st_data = '0;
        end
      endcase
    end
  end

  // Pick the addressed byte/halfword and extend per latched funct3.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      F3_B:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_H:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_BU: ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_HU: ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state logic: errors skip the bus and go straight to RESP.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = issue ? BUS : RESP;
        end
      end
      BUS: begin
        if (mem_ready) begin
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch the accepted op's attributes and fault classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= 2'b00;
      mis_q <= 1'b0;
      ill_q <= 1'b0;
    end else if (accept) begin
      we_q  <= req_we;
      f3_q  <= req_funct3;
      off_q <= req_addr[1:0];
      ill_q <= !f3_legal;
      mis_q <= f3_legal && addr_misal;
    end
  end

  // Registered bus request, held stable until the bus accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_ADDR;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_valid <= 1'b1;
      mem_we    <= req_we;
      mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
      mem_wstrb <= st_strb;
      mem_wdata <= st_data;
    end else if (bus_done) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_ADDR;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
    end
  end

  // Capture extended load data; holds across stores and faults.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (bus_done && !we_q) begin
      rd_data <= ld_ext;
    end
  end

  assign done     = (state == RESP);
  assign rd_valid = done && !we_q && !mis_q && !ill_q;
  assign misalign = done && mis_q;
  assign illegal  = done && ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed ops with a response scoreboard.
// Expected retire results are queued at issue and popped at done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        misalign;
  logic        illegal;
  logic        busy;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.XLEN(32), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .misalign(misalign), .illegal(illegal),
    .busy(busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdv;
    logic [31:0] rdd;
    logic        mis;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)
        || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic m_misal(input logic [2:0] f3,
                                   input logic [31:0] a);
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] v;
    if (f3[0]) s = w >> (off[1] ? 16 : 0);
    else       s = w >> (8 * int'(off));
    v = f3[0] ? (s & 32'h0000FFFF) : (s & 32'h000000FF);
    if (f3 == 3'b010) return w;
    if (f3 == 3'b000 && v[7])  return v | 32'hFFFFFF00;
    if (f3 == 3'b001 && v[15]) return v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                        input logic [1:0] off);
    case (f3)
      3'b000: return 4'b0001 << off;
      3'b001: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    case (f3)
      3'b000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic do_op(input string tag,
                       input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [31:0] rdata,
                       input int waits);
    exp_t e;
    exp_t g;
    logic err;
    logic [31:0] xa;
    logic [31:0] xd;
    logic [3:0] xs;
    int n;
    e.ill = !m_legal(we, f3);
    e.mis = !e.ill && m_misal(f3, addr);
    err   = e.ill || e.mis;
    e.rdv = !err && !we;
    if (e.rdv) last_rd = m_load(f3, addr[1:0], rdata);
    e.rdd = last_rd;
    xa = {addr[31:2], 2'b00};
    xs = we ? m_strb(f3, addr[1:0]) : 4'b0000;
    xd = m_wdata(f3, wdata);
    chk({tag, ".req_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (!err) begin
      chk({tag, ".mem_valid"}, mem_valid, 1);
      chk({tag, ".mem_we"}, mem_we, we);
      chk({tag, ".mem_addr"}, mem_addr, xa);
      chk({tag, ".mem_wstrb"}, mem_wstrb, xs);
      if (we) chk({tag, ".mem_wdata"}, mem_wdata, xd);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".req_ready_busy"}, req_ready, 0);
      for (int i = 0; i < waits; i++) begin
        mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".hold_valid"}, mem_valid, 1);
        chk({tag, ".hold_addr"}, mem_addr, xa);
        chk({tag, ".hold_strb"}, mem_wstrb, xs);
        if (we) chk({tag, ".hold_wdata"}, mem_wdata, xd);
        chk({tag, ".hold_busy"}, busy, 1);
        chk({tag, ".hold_ready"}, req_ready, 0);
        chk({tag, ".hold_done"}, done, 0);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end else begin
      chk({tag, ".no_bus"}, mem_valid, 0);
    end
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done_latency"}, n, 0);
    chk({tag, ".done"}, done, 1);
    if (done === 1'b1 && sb.size() > 0) begin
      g = sb.pop_front();
      chk({tag, ".rd_valid"}, rd_valid, g.rdv);
      chk({tag, ".rd_data"}, rd_data, g.rdd);
      chk({tag, ".misalign"}, misalign, g.mis);
      chk({tag, ".illegal"}, illegal, g.ill);
      chk({tag, ".bus_idle"}, mem_valid, 0);
    end
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".rdv_pulse"}, rd_valid, 0);
    chk({tag, ".err_pulse"}, {misalign, illegal}, 0);
    chk({tag, ".ready_after"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.mem_valid", mem_valid, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wstrb", mem_wstrb, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.done", done, 0);
    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_op("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
    do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
    do_op("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80017F00, 1);
    do_op("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 0);
    do_op("lb1", 1'b0, 3'b000, 32'h101, 32'h0, 32'hAA7BCC00, 0);
    do_op("sh",  1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 0);
    do_op("sb",  1'b1, 3'b000, 32'h201, 32'h00000055, 32'h0, 0);
    do_op("mlw", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    do_op("mlh", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
    do_op("ild", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    do_op("ist", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    do_op("ipri", 1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 0);
    do_op("sw",  1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 3);

    mem_ready = 1'b1;
    @(negedge clk);
    chk("stray.done", done, 0);
    chk("stray.mem_valid", mem_valid, 0);
    chk("stray.rd_data", rd_data, last_rd);
    mem_ready = 1'b0;

    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rbus.mem_valid", mem_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    chk("rbus.drop", mem_valid, 0);
    chk("rbus.req_ready", req_ready, 1);
    chk("rbus.done", done, 0);
    chk("rbus.rd_data", rd_data, last_rd);
    chk("rbus.mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    chk("rbus.done2", done, 0);
    chk("rbus.rdv2", rd_valid, 0);

    do_op("lw2", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 2);

    chk("sb.empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the core ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Runs a single outstanding word-bus transaction with a valid/ready handshake, and returns sign- or zero-extended load data for writeback.
- Flags misaligned or illegal accesses instead of issuing them to the bus.

Parameters:
- XLEN, 32, data/address width. Only 32 is supported.
- RESET_ADDR, 32'h0, value driven on mem_addr while idle or in reset.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core requests a memory op this cycle
- req_ready  output  1  unit can accept a request (combinational: state==IDLE)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (size/sign)
- req_addr  input  XLEN  effective address (ALU result[XLEN-1:0])
- req_wdata  input  XLEN  store data (rs2)
- rd_valid  output  1  one-cycle pulse, load data valid
- rd_data  output  XLEN  extended load result
- done  output  1  one-cycle pulse, op retired (load, store or error)
- misalign  output  1  one-cycle pulse with done, address misaligned
- illegal  output  1  one-cycle pulse with done, unsupported funct3
- busy  output  1  state!=IDLE (core stall)
- mem_valid  output  1  bus request, registered
- mem_ready  input  1  bus accept/complete
- mem_we  output  1  bus write
- mem_addr  output  XLEN  word address, bits[1:0]=0
- mem_wstrb  output  4  byte enables
- mem_wdata  output  XLEN  lane-replicated store data
- mem_rdata  input  XLEN  read word, valid when mem_valid&&mem_ready&&!mem_we

Behaviour:
- Reset values, applied synchronously: state IDLE; mem_valid=0, mem_we=0, mem_addr=RESET_ADDR, mem_wstrb=0, mem_wdata=0; rd_valid=done=misalign=illegal=0; rd_data=0.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Alignment: a halfword needs addr[0]=0; a word needs addr[1:0]=00.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - Accept when req_valid&&req_ready.
  - Illegal funct3 -> RESP with illegal=1. Illegal has priority over misaligned.
  - Misaligned -> RESP with misalign=1.
  - Either error: no bus request.
  - Otherwise latch the request and go to BUS, registering mem_valid=1, mem_we, mem_addr={addr[31:2],2'b00}, mem_wstrb, mem_wdata.
- BUS:
  - mem_valid and all mem_* outputs stay stable until mem_ready=1.
  - On mem_ready: mem_valid drops at that edge; a load captures and extends mem_rdata into rd_data. Go to RESP.
- RESP: for exactly one cycle, done=1; rd_valid=1 only for a successful load. Then IDLE.
- Error pulses: misalign/illegal are asserted only during the RESP cycle.
- Store lanes:
  - SB: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb = 0011 if addr[1]=0, else 1100.
  - SW: wdata=wdata, wstrb=1111.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rd_data holds its value until the next load completes. It is not cleared on stores or errors.
- Latency: accept at edge N, mem_valid high in cycle N+1. If mem_ready=1 in N+1, done/rd_valid are high in cycle N+2. Each wait cycle adds 1. Error ops: done in cycle N+1.
- req_valid while busy is ignored (req_ready=0). The core holds the request.
- Reset mid-transaction: mem_valid drops on the reset edge and the transaction is abandoned. No done/rd_valid is produced for it, and req_ready=1 the next cycle.
- mem_ready while not in BUS is ignored.

Test Plan:
- LW: addr=0x100, mem_rdata=0xDEADBEEF, mem_ready in the first BUS cycle -> mem_addr=0x100, wstrb=0000, rd_data=0xDEADBEEF, rd_valid 2 cycles after accept.
- LB/LBU: addr=0x103, mem_rdata=0x80123456 -> LB rd_data=0xFFFFFF80, LBU rd_data=0x00000080, mem_addr=0x100.
- SH: addr=0x206, wdata=0x1234ABCD -> mem_wdata=0xABCDABCD, wstrb=1100, mem_we=1, done pulse, no rd_valid.
- Misaligned LW at 0x102 -> no mem_valid, done+misalign one cycle after accept. funct3=011 load -> done+illegal, no bus request.
- mem_ready held low 3 cycles on SW 0x40 -> mem_valid/addr/wdata/wstrb stable for 4 BUS cycles, busy=1, req_ready=0, done the cycle after mem_ready.
- rst asserted during BUS -> next cycle mem_valid=0, req_ready=1, no done. A following LW completes normally.
